mp_frame_ctrl: RTL and testbench

- Sequences one MotionPredict pass per selected frame: starts the predictor, serves each pixel-coordinate request from the shared frame-buffer SRAM, and latches the four extreme points into a held result set.
- Shares the SRAM read port with the VGA display reader. The display always has priority.
- Sits between frame capture/SRAM and the tracking logic that consumes target position.

---
 rtl/mp_pkg.sv | 40 ++++
 rtl/mp_pix_addr.sv | 46 ++++
 rtl/mp_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mp_frame_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_pkg.sv
// Shared types and helpers for the MotionPredict frame controller.
//   - mp_state_e       : controller FSM states
//   - NOT_FOUND        : predictor "no pixel" marker
//   - point_t / box_t  : packed {x, y} point and {up, down, left, right} result set
//   - WIDTH_DEF/HEIGHT_DEF : default frame geometry
//   - rgb565_to_rgb888 : colour expansion by replicating the top bits of each channel
package mp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitReq,
        StIssue,
        StWaitData,
        StDeliver,
        StWaitRes
    } mp_state_e;

    localparam logic [10:0] NOT_FOUND = 11'd2023;

    localparam int unsigned WIDTH_DEF  = 640;
    localparam int unsigned HEIGHT_DEF = 480;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
    } point_t;

    typedef struct packed {
        point_t up;
        point_t down;
        point_t left;
        point_t right;
    } box_t;

    function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

endpackage

// File: rtl/mp_pix_addr.sv
// Registered pixel address generator: addr = BASE_ADDR + y*WIDTH + x.
// The multiply is unrolled into shifted adds of y for each set bit of WIDTH.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_load         capture a new coordinate this cycle
//   i_x, i_y       pixel coordinate
//   o_addr         20-bit SRAM word address, valid the cycle after i_load
module mp_pix_addr #(
    parameter int unsigned WIDTH     = 640,
    parameter logic [19:0] BASE_ADDR = 20'd0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [10:0] i_x,
    input  logic [10:0] i_y,
    output logic [19:0] o_addr
);

    localparam logic [19:0] WidthV = 20'(WIDTH);

    logic [19:0] prod;
    logic [19:0] addr_d;
    logic [19:0] addr_q;

    always_comb begin
        prod = '0;
        for (int i = 0; i < 20; i++) begin
            if (WidthV[i]) begin
                prod = prod + ({9'd0, i_y} << i);
            end
        end
        addr_d = BASE_ADDR + prod + {9'd0, i_x};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q <= '0;
        end else if (i_load) begin
            addr_q <= addr_d;
        end
    end

    assign o_addr = addr_q;

endmodule

// File: rtl/mp_frame_ctrl.sv
// MotionPredict frame controller. Starts one predictor pass per selected frame, serves each
// pixel request from the frame-buffer SRAM (the display reader always wins the read port),
// and latches the predictor's four extreme points plus a derived centre.
// Ports:
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_enable, i_frame_done      pass gating and new-frame pulse
//   o_mp_start                  one-cycle start pulse to the predictor
//   i_mp_coord_valid/x/y        predictor pixel request
//   o_mp_valid, o_mp_r/g/b      pixel reply (colour zero when not valid)
//   i_mp_o_valid, i_up..i_right predictor result, packed {x, y}
//   i_disp_req                  display owns the SRAM this cycle
//   o_sram_rd/addr, i_sram_data SRAM read port (RGB565 data)
//   o_busy, o_res_valid, o_found, o_cx, o_cy, o_box, o_err  status and held result
module mp_frame_ctrl #(
    parameter int unsigned WIDTH     = mp_pkg::WIDTH_DEF,
    parameter int unsigned HEIGHT    = mp_pkg::HEIGHT_DEF,
    parameter logic [19:0] BASE_ADDR = 20'd0,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned TIMEOUT   = 4096,
    parameter logic [10:0] NOT_FOUND = mp_pkg::NOT_FOUND
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_frame_done,
    output logic        o_mp_start,
    input  logic        i_mp_coord_valid,
    input  logic [10:0] i_mp_x,
    input  logic [10:0] i_mp_y,
    output logic        o_mp_valid,
    output logic [7:0]  o_mp_r,
    output logic [7:0]  o_mp_g,
    output logic [7:0]  o_mp_b,
    input  logic        i_mp_o_valid,
    input  logic [21:0] i_up,
    input  logic [21:0] i_down,
    input  logic [21:0] i_left,
    input  logic [21:0] i_right,
    input  logic        i_disp_req,
    output logic        o_sram_rd,
    output logic [19:0] o_sram_addr,
    input  logic [15:0] i_sram_data,
    output logic        o_busy,
    output logic        o_res_valid,
    output logic        o_found,
    output logic [10:0] o_cx,
    output logic [10:0] o_cy,
    output logic [87:0] o_box,
    output logic        o_err
);

    import mp_pkg::*;

    // Whole frame must fit in the 20-bit SRAM address space.
    if (64'(BASE_ADDR) + 64'(WIDTH) * 64'(HEIGHT) > 64'd1048576) begin : g_geom_check
        $error("mp_frame_ctrl: frame does not fit in 20-bit address space");
    end

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    mp_state_e       state_q;
    logic [3:0]      div_q;
    logic [TmoW-1:0] tmo_q;
    logic [2:0]      lat_q;
    logic            mp_start_q;
    logic            mp_valid_q;
    logic [23:0]     rgb_q;
    logic            res_valid_q;
    logic            found_q;
    logic [10:0]     cx_q;
    logic [10:0]     cy_q;
    box_t            box_q;
    logic            err_q;

    box_t        box_d;
    logic        found_d;
    logic [11:0] sum_x;
    logic [11:0] sum_y;
    logic        addr_load;

    always_comb begin
        box_d   = box_t'({i_up, i_down, i_left, i_right});
        found_d = (box_d.left.x != NOT_FOUND) && (box_d.up.y != NOT_FOUND);
        sum_x   = {1'b0, box_d.left.x} + {1'b0, box_d.right.x};
        sum_y   = {1'b0, box_d.up.y} + {1'b0, box_d.down.y};
    end

    // The address register doubles as the x/y latch: it loads on the request cycle so the
    // address is already valid in the first ISSUE cycle.
    assign addr_load = (state_q == StWaitReq) && i_mp_coord_valid;

    mp_pix_addr #(
        .WIDTH     (WIDTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_pix_addr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (addr_load),
        .i_x    (i_mp_x),
        .i_y    (i_mp_y),
        .o_addr (o_sram_addr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            tmo_q       <= '0;
            lat_q       <= '0;
            mp_start_q  <= 1'b0;
            mp_valid_q  <= 1'b0;
            rgb_q       <= '0;
            res_valid_q <= 1'b0;
            found_q     <= 1'b0;
            cx_q        <= NOT_FOUND;
            cy_q        <= NOT_FOUND;
            box_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            mp_start_q  <= 1'b0;
            mp_valid_q  <= 1'b0;
            rgb_q       <= '0;
            res_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tmo_q <= '0;
                    if (i_enable && i_frame_done) begin
                        if (div_q == 4'(FRAME_DIV - 1)) begin
                            div_q      <= '0;
                            mp_start_q <= 1'b1;
                            state_q    <= StStart;
                        end else begin
                            div_q <= div_q + 4'd1;
                        end
                    end
                end
                StStart: begin
                    tmo_q   <= '0;
                    state_q <= StWaitReq;
                end
                StWaitReq: begin
                    if (i_mp_coord_valid) begin
                        tmo_q   <= '0;
                        state_q <= StIssue;
                    end else if (i_mp_o_valid) begin
                        box_q       <= box_d;
                        found_q     <= found_d;
                        cx_q        <= found_d ? sum_x[11:1] : NOT_FOUND;
                        cy_q        <= found_d ? sum_y[11:1] : NOT_FOUND;
                        res_valid_q <= 1'b1;
                        tmo_q       <= '0;
                        state_q     <= StIdle;
                    end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StIssue: begin
                    lat_q <= '0;
                    if (!i_disp_req) begin
                        state_q <= StWaitData;
                    end
                end
                StWaitData: begin
                    if (lat_q == 3'(RD_LAT - 1)) begin
                        mp_valid_q <= 1'b1;
                        rgb_q      <= rgb565_to_rgb888(i_sram_data);
                        state_q    <= StDeliver;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                StDeliver: begin
                    tmo_q   <= '0;
                    state_q <= StWaitReq;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Read strobe is combinational so it can never collide with a display cycle.
    assign o_sram_rd   = (state_q == StIssue) && !i_disp_req;
    assign o_busy      = (state_q != StIdle);
    assign o_mp_start  = mp_start_q;
    assign o_mp_valid  = mp_valid_q;
    assign o_mp_r      = rgb_q[23:16];
    assign o_mp_g      = rgb_q[15:8];
    assign o_mp_b      = rgb_q[7:0];
    assign o_res_valid = res_valid_q;
    assign o_found     = found_q;
    assign o_cx        = cx_q;
    assign o_cy        = cy_q;
    assign o_box       = box_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_mp_frame_ctrl.sv
module tb_mp_frame_ctrl;

    localparam int RdLat = 2;
    localparam int Tmo   = 64;
    localparam int Width = 640;
    localparam int Nf    = 2023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, frame_done, coord_valid, mp_o_valid, disp_req;
    logic [10:0] mp_x, mp_y;
    logic [21:0] pt_up, pt_down, pt_left, pt_right;
    logic [15:0] sram_data;

    logic        mp_start, mp_valid, sram_rd, busy, res_valid, found, err;
    logic [7:0]  mp_r, mp_g, mp_b;
    logic [19:0] sram_addr;
    logic [10:0] cx, cy;
    logic [87:0] box;

    // Second instance only exercises frame division.
    logic        fd3, ov3, start3, busy3;
    logic        d3_valid, d3_rd, d3_resv, d3_found, d3_err;
    logic [7:0]  d3_r, d3_g, d3_b;
    logic [19:0] d3_addr;
    logic [10:0] d3_cx, d3_cy;
    logic [87:0] d3_box;

    int          n_checks = 0;
    int          n_bad = 0;
    int          n_start3 = 0;
    logic [15:0] cur_word;
    logic [RdLat-1:0] pipe;
    logic [23:0] obs_rgb;

    mp_frame_ctrl #(
        .WIDTH(Width), .HEIGHT(480), .BASE_ADDR(20'd0), .RD_LAT(RdLat),
        .FRAME_DIV(1), .TIMEOUT(Tmo), .NOT_FOUND(11'd2023)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_frame_done(frame_done),
        .o_mp_start(mp_start), .i_mp_coord_valid(coord_valid), .i_mp_x(mp_x), .i_mp_y(mp_y),
        .o_mp_valid(mp_valid), .o_mp_r(mp_r), .o_mp_g(mp_g), .o_mp_b(mp_b),
        .i_mp_o_valid(mp_o_valid), .i_up(pt_up), .i_down(pt_down), .i_left(pt_left),
        .i_right(pt_right), .i_disp_req(disp_req), .o_sram_rd(sram_rd),
        .o_sram_addr(sram_addr), .i_sram_data(sram_data), .o_busy(busy),
        .o_res_valid(res_valid), .o_found(found), .o_cx(cx), .o_cy(cy), .o_box(box),
        .o_err(err)
    );

    mp_frame_ctrl #(
        .WIDTH(Width), .HEIGHT(480), .BASE_ADDR(20'd0), .RD_LAT(RdLat),
        .FRAME_DIV(3), .TIMEOUT(Tmo), .NOT_FOUND(11'd2023)
    ) dut3 (
        .i_clk(clk), .i_rst(rst), .i_enable(1'b1), .i_frame_done(fd3),
        .o_mp_start(start3), .i_mp_coord_valid(1'b0), .i_mp_x(11'd0), .i_mp_y(11'd0),
        .o_mp_valid(d3_valid), .o_mp_r(d3_r), .o_mp_g(d3_g), .o_mp_b(d3_b),
        .i_mp_o_valid(ov3), .i_up(22'd0), .i_down(22'd0), .i_left(22'd0),
        .i_right(22'd0), .i_disp_req(1'b0), .o_sram_rd(d3_rd),
        .o_sram_addr(d3_addr), .i_sram_data(16'd0), .o_busy(busy3),
        .o_res_valid(d3_resv), .o_found(d3_found), .o_cx(d3_cx), .o_cy(d3_cy),
        .o_box(d3_box), .o_err(d3_err)
    );

    // SRAM model: data for a read appears RdLat cycles after the strobe, junk otherwise.
    always @(posedge clk) begin
        pipe[0] <= sram_rd;
        for (int i = 1; i < RdLat; i++) pipe[i] <= pipe[i-1];
        if (start3) n_start3 <= n_start3 + 1;
    end
    assign sram_data = pipe[RdLat-1] ? cur_word : 16'h0BAD;

    task automatic check_eq(input string tag, input logic [87:0] got, input logic [87:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [15:0] w);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(w) / 2048;
        g6 = (int'(w) / 32) % 64;
        b5 = int'(w) % 32;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return 24'(r8 * 65536 + g8 * 256 + b8);
    endfunction

    function automatic logic [21:0] mk_pt(input int x, input int y);
        logic [10:0] xs, ys;
        xs = 11'(x);
        ys = 11'(y);
        return {xs, ys};
    endfunction

    task automatic start_pass();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        #1;
        check_eq("start_pulse", {1'b0, mp_start}, 2'b01);
        @(negedge clk);
        #1;
        check_eq("start_width", {busy, mp_start}, 2'b10);
    endtask

    task automatic serve(input int x, input int y, input logic [15:0] word, input int stall);
        int k, reads;
        bit done;
        @(negedge clk);
        coord_valid = 1'b1;
        mp_x = 11'(x);
        mp_y = 11'(y);
        cur_word = word;
        k = 0;
        reads = 0;
        done = 1'b0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            coord_valid = 1'b0;
            disp_req = (k <= stall);
            #1;
            if (sram_rd) begin
                reads++;
                check_eq("sram_addr", sram_addr, 88'(y * Width + x));
                if (disp_req) check_eq("rd_vs_disp", 1, 0);
            end
            if (mp_valid) begin
                done = 1'b1;
                obs_rgb = {mp_r, mp_g, mp_b};
            end
        end
        disp_req = 1'b0;
        check_eq("latency", k, RdLat + 2 + stall);
        check_eq("read_count", reads, 1);
        check_eq("rgb", obs_rgb, exp_rgb(word));
        @(negedge clk);
        #1;
        check_eq("rgb_idle_zero", {mp_valid, mp_r, mp_g, mp_b}, 0);
    endtask

    task automatic finish_pass(input logic [21:0] u, input logic [21:0] d,
                               input logic [21:0] l, input logic [21:0] r);
        int ex_cx, ex_cy;
        bit ex_found;
        ex_found = (int'(l[21:11]) != Nf) && (int'(u[10:0]) != Nf);
        ex_cx = ex_found ? (int'(l[21:11]) + int'(r[21:11])) / 2 : Nf;
        ex_cy = ex_found ? (int'(u[10:0]) + int'(d[10:0])) / 2 : Nf;
        @(negedge clk);
        mp_o_valid = 1'b1;
        pt_up = u;
        pt_down = d;
        pt_left = l;
        pt_right = r;
        @(negedge clk);
        mp_o_valid = 1'b0;
        #1;
        check_eq("res_valid", {busy, res_valid}, 2'b01);
        check_eq("box", box, {u, d, l, r});
        check_eq("found", found, ex_found);
        check_eq("cx", cx, ex_cx);
        check_eq("cy", cy, ex_cy);
        @(negedge clk);
        #1;
        check_eq("res_pulse", res_valid, 0);
    endtask

    task automatic pulse3();
        @(negedge clk);
        fd3 = 1'b1;
        @(negedge clk);
        fd3 = 1'b0;
        #1;
    endtask

    task automatic end3();
        @(negedge clk);
        ov3 = 1'b1;
        @(negedge clk);
        ov3 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_pulses, seen;
        logic [87:0] saved_box;
        int k;

        rst = 1'b1;
        enable = 1'b0;
        frame_done = 1'b0;
        coord_valid = 1'b0;
        mp_x = '0;
        mp_y = '0;
        mp_o_valid = 1'b0;
        pt_up = '0;
        pt_down = '0;
        pt_left = '0;
        pt_right = '0;
        disp_req = 1'b0;
        cur_word = '0;
        fd3 = 1'b0;
        ov3 = 1'b0;
        obs_rgb = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ctl", {busy, mp_start, mp_valid, sram_rd, res_valid, found, err}, 0);
        check_eq("rst_cxcy", {cx, cy}, {11'd2023, 11'd2023});
        check_eq("rst_box_addr", {box, sram_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // Directed first pass.
        start_pass();
        serve(5, 2, 16'hF81F, 0);
        check_eq("rgb_f81f", obs_rgb, 24'hFF00FF);
        serve(300, 100, 16'(($urandom)), 10);
        check_eq("no_err_stall", err, 0);
        finish_pass(mk_pt(100, 50), mk_pt(120, 200), mk_pt(80, 90), mk_pt(300, 110));
        check_eq("cx_190", cx, 190);
        check_eq("cy_125", cy, 125);

        start_pass();
        serve(639, 479, 16'(($urandom)), 1);
        finish_pass(mk_pt(10, Nf), mk_pt(20, 30), mk_pt(Nf, 40), mk_pt(50, 60));
        check_eq("nf_cxcy", {found, cx, cy}, {1'b0, 11'd2023, 11'd2023});

        // Randomized passes.
        for (int p = 0; p < 6; p++) begin
            int nreq;
            logic [21:0] u, d, l, r;
            start_pass();
            nreq = $urandom_range(1, 4);
            for (int q = 0; q < nreq; q++) begin
                serve($urandom_range(0, 639), $urandom_range(0, 479), 16'($urandom),
                      $urandom_range(0, 3));
            end
            u = mk_pt($urandom_range(0, 639), $urandom_range(0, 479));
            d = mk_pt($urandom_range(0, 639), $urandom_range(0, 479));
            l = mk_pt($urandom_range(0, 639), $urandom_range(0, 479));
            r = mk_pt($urandom_range(0, 639), $urandom_range(0, 479));
            if ($urandom_range(0, 3) == 0) l = mk_pt(Nf, $urandom_range(0, 479));
            if ($urandom_range(0, 3) == 0) u = mk_pt($urandom_range(0, 639), Nf);
            finish_pass(u, d, l, r);
        end

        // Disabled controller ignores frames.
        enable = 1'b0;
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        #1;
        check_eq("disabled", {busy, mp_start}, 0);
        enable = 1'b1;

        // Frame division by 3, including a pulse while busy.
        idle_pulses = 0;
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            bit while_busy;
            while_busy = (i == 3);
            if (while_busy) check_eq("div_busy_pre", busy3, 1);
            pulse3();
            seen += int'(start3);
            if (while_busy) begin
                check_eq("div_busy_nostart", start3, 0);
                end3();
            end else begin
                idle_pulses++;
                check_eq("div_starts", seen, idle_pulses / 3);
                if (start3 && i != 2) end3();
            end
        end
        end3();
        @(negedge clk);
        check_eq("div_total", n_start3, 2);

        // Predictor silent: timeout.
        saved_box = box;
        start_pass();
        k = 1;
        while (!err && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        // 64 full cycles waiting, flag visible the cycle after.
        check_eq("tmo_cycle", k, Tmo + 1);
        check_eq("tmo_idle", {busy, res_valid}, 0);
        check_eq("tmo_box", box, saved_box);
        start_pass();
        serve(1, 1, 16'h1234, 0);
        finish_pass(mk_pt(1, 2), mk_pt(3, 4), mk_pt(5, 6), mk_pt(7, 8));
        check_eq("err_sticky", err, 1);

        // Reset mid-pass (predictor would be reset alongside).
        start_pass();
        @(negedge clk);
        coord_valid = 1'b1;
        mp_x = 11'd9;
        mp_y = 11'd9;
        @(negedge clk);
        coord_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("midrst_ctl", {busy, sram_rd, err, res_valid, found}, 0);
        check_eq("midrst_cx", cx, Nf);
        rst = 1'b0;

        start_pass();
        serve(17, 33, 16'(($urandom)), 2);
        finish_pass(mk_pt(200, 10), mk_pt(210, 300), mk_pt(150, 100), mk_pt(400, 120));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
